// File: rtl/johnson_code_checker.sv
// rtl/johnson_code_checker.sv - Johnson code legality, decode, ring-order lock checker
module johnson_code_checker #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [WIDTH-1:0]             code,
    output logic [$clog2(2*WIDTH)-1:0]   index,
    output logic                         index_valid,
    output logic                         illegal,
    output logic                         seq_err,
    output logic                         locked,
    output logic [ERR_CNT_W-1:0]         err_count
);

    localparam int IDX_W    = $clog2(2*WIDTH);
    localparam int N_STATES = 2*WIDTH;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  prev;
    logic [3:0]        run;
    logic [3:0]        run_next;

    logic [WIDTH-1:0]  code_inv;
    logic              legal;
    logic [IDX_W-1:0]  dec_idx;
    logic [IDX_W-1:0]  succ;
    logic              correct;
    logic              seq_hit;
    logic              err_hit;
    int                ones;

    // A legal code is a thermometer of ones from the LSB (MSB clear), or the
    // complement of one (MSB set); x & (x+1) == 0 tests for the 0..01..1 shape.
    always_comb begin
        code_inv = ~code;
        if (code[WIDTH-1] == 1'b0)
            legal = ((code & (code + WIDTH'(1))) == '0);
        else
            legal = ((code_inv & (code_inv + WIDTH'(1))) == '0);

        ones = 0;
        for (int i = 0; i < WIDTH; i++)
            ones = ones + int'(code[i]);

        if (code[WIDTH-1])
            dec_idx = IDX_W'(N_STATES - ones);
        else
            dec_idx = IDX_W'(ones);

        if (prev == IDX_W'(N_STATES - 1))
            succ = '0;
        else
            succ = prev + IDX_W'(1);
        correct = (dec_idx == succ);
    end

    always_comb begin
        state_next = state;
        run_next   = run;
        seq_hit    = 1'b0;
        if (en) begin
            if (!legal) begin
                state_next = HUNT;
            end else begin
                case (state)
                    HUNT: begin
                        state_next = CHECK;
                        run_next   = '0;
                    end
                    CHECK: begin
                        if (correct) begin
                            run_next = run + 4'd1;
                            if (run + 4'd1 == 4'(LOCK_COUNT))
                                state_next = LOCKED;
                        end else begin
                            run_next = '0;
                        end
                    end
                    LOCKED: begin
                        if (!correct) begin
                            seq_hit    = 1'b1;
                            state_next = CHECK;
                            run_next   = '0;
                        end
                    end
                    default: begin
                        state_next = HUNT;
                        run_next   = '0;
                    end
                endcase
            end
        end
        err_hit = en && (!legal || seq_hit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            prev        <= '0;
            run         <= '0;
            index       <= '0;
            index_valid <= 1'b0;
            illegal     <= 1'b0;
            seq_err     <= 1'b0;
            locked      <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_next;
            run         <= run_next;
            locked      <= (state_next == LOCKED);
            index_valid <= en && legal;
            illegal     <= en && !legal;
            seq_err     <= seq_hit;
            if (en && legal) begin
                index <= dec_idx;
                prev  <= dec_idx;
            end
            if (err_hit && (err_count != '1))
                err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule
